font_fetch_arbiter: RTL
=======================

# font_fetch_arbiter

Shares the single synchronous font ROM read port between the display pixel pipeline and the host readback port of the VGA text card. The display requester always wins and sees a fixed 2-cycle latency, so scan-out timing is deterministic. The host requester uses a level req/ack handshake and is served only in cycles the display leaves idle. The block sits between the character renderer, the host bus bridge and the font ROM instance.

## Interface
Parameters:
- ADDR_BITS, default `FONTROM_ADDR_BITS, font ROM word address width
- DATA_BITS, default `SYMB_WIDTH, font ROM word (glyph row) width

Ports (single clock `clk`; reset `rst_n`, asynchronous, active-low):
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display read request, one-cycle qualifier, may be high every cycle
- disp_addr  in  ADDR_BITS  display read address, valid with disp_req
- disp_valid  out  1  display data valid pulse
- disp_data  out  DATA_BITS  display read data, held until next disp_valid
- host_req  in  1  host read request, level, held until host_ack
- host_addr  in  ADDR_BITS  host address, stable while host_req high
- host_ack  out  1  host completion pulse, host_data valid this cycle
- host_data  out  DATA_BITS  host read data, held until next host_ack
- host_busy  out  1  host request accepted and not yet acknowledged
- rom_en  out  1  to font ROM enable
- rom_addr  out  ADDR_BITS  to font ROM address
- rom_dout  in  DATA_BITS  from font ROM, valid the cycle after rom_en

## Operation
- Grant (combinational, cycle N): disp_req=1 -> display granted; else host_req=1 and host FSM in H_IDLE -> host granted; else none. rom_en = any grant; rom_addr = granted address (disp_addr when no grant).
- Owner tag pipeline: 2-stage registered tag {disp, host}; stage1 set at edge ending cycle N, stage2 one cycle later; stage2 registers rom_dout into disp_data or host_data.
- Host FSM: H_IDLE -> H_ISSUED on host grant; H_ISSUED -> H_ACK unconditionally; H_ACK -> H_IDLE unconditionally. Host is not re-granted before H_IDLE, so a host_req still high in the ack cycle does not cause a duplicate read. host_busy = state != H_IDLE, or host_req pending in H_IDLE.
- Host starvation is permitted: host waits indefinitely while disp_req stays high.
- host_req dropped before grant: no read issued. Dropped after grant: the read completes and host_ack still pulses.
- disp_data/host_data only change on their own valid/ack pulse.

## Timing
- Reset values: disp_valid=0, host_ack=0, disp_data=0, host_data=0, host_busy=0, host FSM=H_IDLE, tags cleared. rom_en follows inputs combinationally (0 with no requests).
- Display latency: disp_req in cycle N -> disp_valid in cycle N+2. Throughput is 1 per cycle, back-to-back.
- Host latency: grant in cycle G -> host_ack in G+2. Minimum spacing between host grants is 3 cycles.
- Simultaneous disp_req and host_req: display served, host deferred, host_busy=1.
- Reset asserted mid-flight: all in-flight reads discarded, no valid/ack after reset release for them, data regs return to 0.

## Configuration
- FONT_ARB_STATS_EN defined: adds input stat_clr (1) and outputs stat_disp_cnt (16), stat_host_cnt (16), stat_max_wait (8).
  - Grant counters saturate at all-ones.
  - stat_max_wait records the longest host wait in cycles, from host_req rise in H_IDLE to grant, saturating at 255.
  - stat_clr zeroes all three on the next edge; reset also zeroes them.
- Undefined: these ports and their logic are absent, and arbitration behaviour is identical.

## Structure
- Defaults come from vga_defines.vh: FONTROM_ADDR_BITS, SYMB_WIDTH.
- Add FONT_ARB_LATENCY (2) and the host FSM state encodings (H_IDLE=0, H_ISSUED=1, H_ACK=2) to the same header.
- One sub-module, font_arb_stats, holds the counters and is instantiated only under FONT_ARB_STATS_EN.

## Test plan
- Display stream: disp_req high 8 cycles, addrs 0x10..0x17 -> disp_valid cycles 2..9, data = ROM[0x10..0x17] in order.
- Lone host read: host_req, addr 0x2A -> host_ack exactly 2 cycles after grant, host_data=ROM[0x2A]. host_req held through ack -> no second rom_en for 0x2A in the ack cycle.
- Contention: host_req asserted during 5-cycle display burst -> host granted in first disp_req=0 cycle, display valids uninterrupted. stat_max_wait=5 with FONT_ARB_STATS_EN.
- Interleave: disp_req alternating 1/0 with host_req held -> host reads every 3rd cycle at most. Display latency stays 2.
- Reset mid-flight: rst_n low one cycle after disp and host grants -> no disp_valid/host_ack afterwards, outputs 0.
- Stats: 70000 display reads -> stat_disp_cnt=0xFFFF. stat_clr pulse -> all counters 0 next cycle.

Source files
------------

// File: rtl/font_fetch_arbiter_pkg.sv
// Shared definitions for the font ROM fetch arbiter: ROM geometry defaults,
// read latency, host FSM encoding and saturating helpers.
`ifndef FONTROM_ADDR_BITS
`define FONTROM_ADDR_BITS 12
`endif
`ifndef SYMB_WIDTH
`define SYMB_WIDTH 8
`endif

package font_fetch_arbiter_pkg;

  localparam int FONT_ARB_LATENCY = 2;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_ISSUED = 2'd1,
    H_ACK    = 2'd2
  } host_state_e;

  typedef struct packed {
    logic disp;
    logic host;
  } owner_tag_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/font_arb_stats.sv
// Grant counters and longest host wait for the font fetch arbiter; all
// values saturate and are cleared by stat_clr or reset.
module font_arb_stats
  import font_fetch_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stat_clr,
  input  logic        disp_grant,
  input  logic        host_grant,
  input  logic        host_wait,
  output logic [15:0] stat_disp_cnt,
  output logic [15:0] stat_host_cnt,
  output logic [7:0]  stat_max_wait
);

  logic [15:0] disp_cnt_q, disp_cnt_d;
  logic [15:0] host_cnt_q, host_cnt_d;
  logic [7:0]  wait_q, wait_d;
  logic [7:0]  max_wait_q, max_wait_d;

  always_comb begin
    disp_cnt_d = disp_cnt_q;
    host_cnt_d = host_cnt_q;
    max_wait_d = max_wait_q;
    // wait_q holds the number of cycles the pending host request was deferred
    wait_d     = host_wait ? sat_inc8(wait_q) : 8'd0;
    if (disp_grant) disp_cnt_d = sat_inc16(disp_cnt_q);
    if (host_grant) host_cnt_d = sat_inc16(host_cnt_q);
    if (host_grant && (wait_q > max_wait_q)) max_wait_d = wait_q;
    if (stat_clr) begin
      disp_cnt_d = '0;
      host_cnt_d = '0;
      max_wait_d = '0;
      wait_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_cnt_q <= '0;
      host_cnt_q <= '0;
      wait_q     <= '0;
      max_wait_q <= '0;
    end else begin
      disp_cnt_q <= disp_cnt_d;
      host_cnt_q <= host_cnt_d;
      wait_q     <= wait_d;
      max_wait_q <= max_wait_d;
    end
  end

  assign stat_disp_cnt = disp_cnt_q;
  assign stat_host_cnt = host_cnt_q;
  assign stat_max_wait = max_wait_q;

endmodule

// File: rtl/font_fetch_arbiter.sv
// Shares the font ROM read port: display has fixed priority and 2-cycle latency,
// host is served in idle cycles. Optional statistics under FONT_ARB_STATS_EN.
module font_fetch_arbiter
  import font_fetch_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = `FONTROM_ADDR_BITS,
  parameter int DATA_BITS = `SYMB_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 disp_req,
  input  logic [ADDR_BITS-1:0] disp_addr,
  output logic                 disp_valid,
  output logic [DATA_BITS-1:0] disp_data,
  input  logic                 host_req,
  input  logic [ADDR_BITS-1:0] host_addr,
  output logic                 host_ack,
  output logic [DATA_BITS-1:0] host_data,
  output logic                 host_busy,
  output logic                 rom_en,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [DATA_BITS-1:0] rom_dout
`ifdef FONT_ARB_STATS_EN
  ,
  input  logic                 stat_clr,
  output logic [15:0]          stat_disp_cnt,
  output logic [15:0]          stat_host_cnt,
  output logic [7:0]           stat_max_wait
`endif
);

  host_state_e          state_q, state_d;
  owner_tag_t           tag_q [FONT_ARB_LATENCY];
  owner_tag_t           tag_d [FONT_ARB_LATENCY];
  logic [DATA_BITS-1:0] disp_data_q, disp_data_d;
  logic [DATA_BITS-1:0] host_data_q, host_data_d;
  logic                 disp_grant;
  logic                 host_grant;

  // Host only gets the port in cycles the display leaves free, and never
  // while a previous host read is still in flight.
  always_comb begin
    disp_grant = disp_req;
    host_grant = !disp_req && host_req && (state_q == H_IDLE);
    rom_en     = disp_grant || host_grant;
    rom_addr   = host_grant ? host_addr : disp_addr;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      H_IDLE:   if (host_grant) state_d = H_ISSUED;
      H_ISSUED: state_d = H_ACK;
      H_ACK:    state_d = H_IDLE;
      default:  state_d = H_IDLE;
    endcase
  end

  // Stage 1 tag marks the cycle rom_dout is valid; the last stage is the pulse.
  always_comb begin
    tag_d[0] = '{disp: disp_grant, host: host_grant};
    for (int i = 1; i < FONT_ARB_LATENCY; i++) tag_d[i] = tag_q[i-1];
    disp_data_d = tag_q[FONT_ARB_LATENCY-2].disp ? rom_dout : disp_data_q;
    host_data_d = tag_q[FONT_ARB_LATENCY-2].host ? rom_dout : host_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= H_IDLE;
      for (int i = 0; i < FONT_ARB_LATENCY; i++) tag_q[i] <= '0;
      disp_data_q <= '0;
      host_data_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      disp_data_q <= disp_data_d;
      host_data_q <= host_data_d;
    end
  end

  assign disp_valid = tag_q[FONT_ARB_LATENCY-1].disp;
  assign host_ack   = tag_q[FONT_ARB_LATENCY-1].host;
  assign disp_data  = disp_data_q;
  assign host_data  = host_data_q;
  assign host_busy  = (state_q != H_IDLE) || host_req;

`ifdef FONT_ARB_STATS_EN
  font_arb_stats u_stats (
    .clk           (clk),
    .rst_n         (rst_n),
    .stat_clr      (stat_clr),
    .disp_grant    (disp_grant),
    .host_grant    (host_grant),
    .host_wait     (host_req && (state_q == H_IDLE) && !host_grant),
    .stat_disp_cnt (stat_disp_cnt),
    .stat_host_cnt (stat_host_cnt),
    .stat_max_wait (stat_max_wait)
  );
`endif

endmodule
